// File: rtl/ram_copy_pkg.sv
// Shared definitions for the RAM block-copy engine and the RAM instances it drives.
package ram_copy_pkg;

    localparam int RAM_A = 10;
    localparam int RAM_D = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_copy_dma_if.sv
// Single-port synchronous RAM port: the engine drives it as master, the RAM answers as slave.
interface ram_copy_dma_if #(
    parameter int A = ram_copy_pkg::RAM_A,
    parameter int D = ram_copy_pkg::RAM_D
);
    logic [A-1:0] mem_addr;
    logic [D-1:0] mem_din;
    logic [D-1:0] mem_dout;
    logic         mem_we;

    modport master (output mem_addr, output mem_din, output mem_we, input  mem_dout);
    modport slave  (input  mem_addr, input  mem_din, input  mem_we, output mem_dout);
endinterface

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with registered read data (one-cycle read latency).
module ram_sync
    import ram_copy_pkg::*;
#(
    parameter int A = RAM_A,
    parameter int D = RAM_D
) (
    input  logic         clk,
    input  logic [A-1:0] addr_i,
    input  logic [D-1:0] din_i,
    input  logic         we_i,
    output logic [D-1:0] dout_o
);
    logic [D-1:0] mem_q [2**A];

    // NOTE: the storage array has no reset; clearing a RAM needs a write per word, not a reset branch.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= din_i;
        dout_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/ram_copy_dma.sv
// Forward block-copy engine on a single-port sync RAM: one word per RD/WR pair.
// Optional fill mode (constant pattern, one word per cycle) under RAM_COPY_DMA_FILL_EN.
module ram_copy_dma
    import ram_copy_pkg::*;
#(
    parameter int A = RAM_A,
    parameter int D = RAM_D
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [A-1:0]  src,
    input  logic [A-1:0]  dst,
    input  logic [A:0]    len,
`ifdef RAM_COPY_DMA_FILL_EN
    input  logic          fill,
    input  logic [D-1:0]  pattern,
`endif
    output logic          busy,
    output logic          done,
    ram_copy_dma_if.master mem
);
    state_e       state_q;
    logic         busy_q;
    logic         done_q;
    logic [A-1:0] src_q;
    logic [A-1:0] dst_q;
    logic [A:0]   cnt_q;
    logic         fill_cmd;
    logic         fill_run;
    logic [D-1:0] pattern_run;

`ifdef RAM_COPY_DMA_FILL_EN
    logic         fill_q;
    logic [D-1:0] pattern_q;

    assign fill_cmd    = fill;
    assign fill_run    = fill_q;
    assign pattern_run = pattern_q;
`else
    assign fill_cmd    = 1'b0;
    assign fill_run    = 1'b0;
    assign pattern_run = '0;
`endif

    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
`ifdef RAM_COPY_DMA_FILL_EN
            fill_q    <= 1'b0;
            pattern_q <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q  <= src;
                        dst_q  <= dst;
                        cnt_q  <= len;
                        busy_q <= 1'b1;
`ifdef RAM_COPY_DMA_FILL_EN
                        fill_q    <= fill;
                        pattern_q <= pattern;
`endif
                        if (len == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= fill_cmd ? ST_WR : ST_RD;
                        end
                    end
                end
                ST_RD: state_q <= ST_WR;
                ST_WR: begin
                    src_q <= src_q + 1'b1;
                    dst_q <= dst_q + 1'b1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == (A+1)'(1)) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= fill_run ? ST_WR : ST_RD;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // The RAM port decodes only from registered state; read data passes through in WR.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem.mem_addr = '0;
        mem.mem_din  = '0;
        mem.mem_we   = 1'b0;
        unique case (state_q)
            ST_RD: mem.mem_addr = src_q;
            ST_WR: begin
                mem.mem_addr = dst_q;
                mem.mem_din  = fill_run ? pattern_run : mem.mem_dout;
                mem.mem_we   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ram_copy_dma.sv
// Directed bench for ram_copy_dma driving a ram_sync responder; fill test under RAM_COPY_DMA_FILL_EN.
module tb_ram_copy_dma;
    import ram_copy_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  src;
    logic [9:0]  dst;
    logic [10:0] len;
    logic        busy;
    logic        done;
`ifdef RAM_COPY_DMA_FILL_EN
    logic        fill;
    logic [7:0]  pattern;
`endif

    logic        tb_sel;
    logic [9:0]  tb_addr;
    logic [7:0]  tb_din;
    logic        tb_we;
    logic [7:0]  ram_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_copy_dma_if #(.A(10), .D(8)) bus ();

    ram_copy_dma #(.A(10), .D(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .src    (src),
        .dst    (dst),
        .len    (len),
`ifdef RAM_COPY_DMA_FILL_EN
        .fill   (fill),
        .pattern(pattern),
`endif
        .busy   (busy),
        .done   (done),
        .mem    (bus)
    );

    ram_sync #(.A(10), .D(8)) ram_u (
        .clk   (clk),
        .addr_i(tb_sel ? tb_addr : bus.mem_addr),
        .din_i (tb_sel ? tb_din  : bus.mem_din),
        .we_i  (tb_sel ? tb_we   : bus.mem_we),
        .dout_o(ram_dout)
    );
    assign bus.mem_dout = ram_dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ram_wr(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_sel = 1'b1; tb_addr = a; tb_din = d; tb_we = 1'b1;
        @(negedge clk);
        tb_we = 1'b0; tb_sel = 1'b0;
    endtask

    function automatic logic [7:0] ram_at(input logic [9:0] a);
        return ram_u.mem_q[a];
    endfunction

    // Issues one command, then watches a bounded window; extra_at>0 pulses a rogue start.
    task automatic run_cmd(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                           input int extra_at, output int lat, output int busy_n,
                           output int we_n, output int done_n,
                           output logic [9:0] addr1, output logic [9:0] addr2);
        int budget;
        budget = 2 * int'(n) + 6;
        lat = -1; busy_n = 0; we_n = 0; done_n = 0; addr1 = '0; addr2 = '0;
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = n;
        @(posedge clk);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (extra_at != 0 && k == extra_at) begin
                start = 1'b1; src = 10'h050; dst = 10'h300; len = 11'd2;
            end
            if (extra_at != 0 && k == extra_at + 1) start = 1'b0;
            if (busy) busy_n++;
            if (bus.mem_we) we_n++;
            if (done) begin
                done_n++;
                if (lat < 0) lat = k;
            end
            if (k == 1) addr1 = bus.mem_addr;
            if (k == 2) addr2 = bus.mem_addr;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat, busy_n, we_n, done_n;
        logic [9:0] a1, a2;

        rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        tb_sel = 1'b0; tb_addr = '0; tb_din = '0; tb_we = 1'b0;
`ifdef RAM_COPY_DMA_FILL_EN
        fill = 1'b0; pattern = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_addr", bus.mem_addr, 10'h000);
        check("rst_din", bus.mem_din, 8'h00);
        rst_n = 1'b1;

        // Basic copy of four words.
        ram_wr(10'h010, 8'd11); ram_wr(10'h011, 8'd22);
        ram_wr(10'h012, 8'd33); ram_wr(10'h013, 8'd44);
        ram_wr(10'h014, 8'd55); ram_wr(10'h015, 8'd66);
        ram_wr(10'h104, 8'hEE);
        run_cmd(10'h010, 10'h100, 11'd4, 0, lat, busy_n, we_n, done_n, a1, a2);
        check("cp4_lat", lat, 9);
        check("cp4_busy", busy_n, 9);
        check("cp4_we", we_n, 4);
        check("cp4_done", done_n, 1);
        check("cp4_rd_addr", a1, 10'h010);
        check("cp4_wr_addr", a2, 10'h100);
        check("cp4_m100", ram_at(10'h100), 8'd11);
        check("cp4_m101", ram_at(10'h101), 8'd22);
        check("cp4_m102", ram_at(10'h102), 8'd33);
        check("cp4_m103", ram_at(10'h103), 8'd44);
        check("cp4_m104", ram_at(10'h104), 8'hEE);

        // Zero-length command.
        run_cmd(10'h010, 10'h140, 11'd0, 0, lat, busy_n, we_n, done_n, a1, a2);
        check("len0_lat", lat, 1);
        check("len0_busy", busy_n, 1);
        check("len0_we", we_n, 0);

        // Wrapping source overlapping the destination: word 4 re-reads the freshly written 0x001.
        ram_wr(10'h3FE, 8'h61); ram_wr(10'h3FF, 8'h62);
        ram_wr(10'h000, 8'h63); ram_wr(10'h001, 8'h64);
        ram_wr(10'h002, 8'h00); ram_wr(10'h003, 8'h00); ram_wr(10'h004, 8'h00);
        run_cmd(10'h3FE, 10'h001, 11'd4, 0, lat, busy_n, we_n, done_n, a1, a2);
        check("wrap_lat", lat, 9);
        check("wrap_m001", ram_at(10'h001), 8'h61);
        check("wrap_m002", ram_at(10'h002), 8'h62);
        check("wrap_m003", ram_at(10'h003), 8'h63);
        check("wrap_m004", ram_at(10'h004), 8'h61);
        check("wrap_m000", ram_at(10'h000), 8'h63);

        // Start while busy is ignored.
        for (int i = 0; i < 8; i++) ram_wr(10'(i), 8'(8'h80 + i));
        ram_wr(10'h300, 8'hEE); ram_wr(10'h301, 8'hEE);
        run_cmd(10'h000, 10'h200, 11'd8, 3, lat, busy_n, we_n, done_n, a1, a2);
        check("ign_lat", lat, 17);
        check("ign_done", done_n, 1);
        check("ign_we", we_n, 8);
        check("ign_busy", busy_n, 17);
        check("ign_m200", ram_at(10'h200), 8'h80);
        check("ign_m203", ram_at(10'h203), 8'h83);
        check("ign_m207", ram_at(10'h207), 8'h87);
        check("ign_m300", ram_at(10'h300), 8'hEE);

        // Reset during the third WR cycle of a six-word copy.
        for (int i = 0; i < 6; i++) ram_wr(10'(10'h180 + i), 8'hCC);
        @(negedge clk);
        start = 1'b1; src = 10'h010; dst = 10'h180; len = 11'd6;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        check("abort_pre_we", bus.mem_we, 1'b1);
        check("abort_pre_addr", bus.mem_addr, 10'h182);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_we", bus.mem_we, 1'b0);
        check("abort_addr", bus.mem_addr, 10'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_m180", ram_at(10'h180), 8'd11);
        check("abort_m181", ram_at(10'h181), 8'd22);
        check("abort_m182", ram_at(10'h182), 8'hCC);
        check("abort_m185", ram_at(10'h185), 8'hCC);
        run_cmd(10'h012, 10'h190, 11'd2, 0, lat, busy_n, we_n, done_n, a1, a2);
        check("post_lat", lat, 5);
        check("post_m190", ram_at(10'h190), 8'd33);
        check("post_m191", ram_at(10'h191), 8'd44);

`ifdef RAM_COPY_DMA_FILL_EN
        for (int i = 0; i < 5; i++) ram_wr(10'(10'h020 + i), 8'h00);
        ram_wr(10'h025, 8'h5A);
        fill = 1'b1; pattern = 8'hA5;
        run_cmd(10'h3F0, 10'h020, 11'd5, 0, lat, busy_n, we_n, done_n, a1, a2);
        fill = 1'b0; pattern = 8'h00;
        check("fill_lat", lat, 6);
        check("fill_busy", busy_n, 6);
        check("fill_we", we_n, 5);
        check("fill_addr1", a1, 10'h020);
        check("fill_addr2", a2, 10'h021);
        check("fill_m020", ram_at(10'h020), 8'hA5);
        check("fill_m024", ram_at(10'h024), 8'hA5);
        check("fill_m025", ram_at(10'h025), 8'h5A);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
